// File: rtl/divider_nr_hs_if.sv
// divider_nr_hs_if: operand/result handshake bundle for the non-restoring divider
interface divider_nr_hs_if #(parameter int BITS = 16);
  logic            in_valid;
  logic            in_ready;
  logic            signed_mode;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;
  logic            overflow;
  modport master (
    output in_valid, signed_mode, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, signed_mode, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_nr_hs.sv
// divider_nr_hs: iterative non-restoring divider, one quotient bit per clock, signed/unsigned, valid/ready
module divider_nr_hs #(
  parameter int BITS       = 16,
  parameter bit EARLY_TERM = 1'b1
) (
  input logic             clk,
  input logic             rst,
  divider_nr_hs_if.slave  io
);
  localparam int CW = $clog2(BITS) + 1;
  typedef enum logic [2:0] {IDLE, INIT, ITER, FIX, SIGN, DONE} state_t;
  state_t          state_q;
  logic [BITS-1:0] a_q, b_q, dvs_q, quo_q, q_out_q, r_out_q;
  logic [BITS:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic            sm_q, sq_q, sr_q, dbz_q, ovf_q, ov_q;
  logic [BITS-1:0] abs_a, abs_b, shifted;
  logic [CW-1:0]   n_d, sh;
  logic [BITS:0]   shl, rem_step;
  assign abs_a = (sm_q && a_q[BITS-1]) ? -a_q : a_q;
  assign abs_b = (sm_q && b_q[BITS-1]) ? -b_q : b_q;
  always_comb begin
    n_d = '0;
    for (int i = 0; i < BITS; i++)
      if (abs_a[i]) n_d = CW'(i + 1);
    if (!EARLY_TERM) n_d = CW'(BITS);
  end
  assign sh       = CW'(BITS) - n_d;
  assign shifted  = abs_a << sh;
  // arithmetic wraps mod 2^(BITS+1); the true step result always fits there
  assign shl      = {rem_q[BITS-1:0], quo_q[BITS-1]};
  assign rem_step = rem_q[BITS] ? shl + {1'b0, dvs_q} : shl - {1'b0, dvs_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      sm_q    <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          a_q     <= io.dividend;
          b_q     <= io.divisor;
          sm_q    <= io.signed_mode;
          dbz_q   <= 1'b0;
          ovf_q   <= 1'b0;
          state_q <= INIT;
        end
        INIT: begin
          sq_q    <= sm_q & (a_q[BITS-1] ^ b_q[BITS-1]);
          sr_q    <= sm_q & a_q[BITS-1];
          dvs_q   <= abs_b;
          quo_q   <= shifted;
          rem_q   <= '0;
          cnt_q   <= n_d;
          state_q <= (b_q == '0) ? SIGN : (n_d == '0) ? FIX : ITER;
        end
        ITER: begin
          rem_q   <= rem_step;
          quo_q   <= {quo_q[BITS-2:0], ~rem_step[BITS]};
          cnt_q   <= cnt_q - CW'(1);
          state_q <= (cnt_q == CW'(1)) ? FIX : ITER;
        end
        FIX: begin
          rem_q   <= rem_q[BITS] ? rem_q + {1'b0, dvs_q} : rem_q;
          state_q <= SIGN;
        end
        SIGN: begin
          q_out_q <= (b_q == '0) ? '1 : sq_q ? -quo_q : quo_q;
          r_out_q <= (b_q == '0) ? a_q : sr_q ? -rem_q[BITS-1:0] : rem_q[BITS-1:0];
          dbz_q   <= (b_q == '0);
          ovf_q   <= sm_q && (a_q == {1'b1, {(BITS-1){1'b0}}}) && (b_q == '1);
          ov_q    <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (io.out_ready) begin
          ov_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign io.in_ready    = (state_q == IDLE);
  assign io.out_valid   = ov_q;
  assign io.quotient    = q_out_q;
  assign io.remainder   = r_out_q;
  assign io.div_by_zero = dbz_q;
  assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_divider_nr_hs.sv
// tb_divider_nr_hs: directed and random division checks against an integer-arithmetic reference
module tb_divider_nr_hs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  divider_nr_hs_if #(.BITS(16)) io ();
  divider_nr_hs #(.BITS(16), .EARLY_TERM(1'b1)) dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sm,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dbz, output logic ovf, output int lat);
    int ia, ib, mag, n;
    dbz = (b == 16'd0);
    ovf = 1'b0;
    q   = 16'hFFFF;
    r   = a;
    lat = 2;
    if (dbz) return;
    ia  = sm ? int'($signed(a)) : int'(a);
    ib  = sm ? int'($signed(b)) : int'(b);
    q   = 16'(ia / ib);
    r   = 16'(ia % ib);
    ovf = sm && ia == -32768 && ib == -1;
    mag = ia < 0 ? -ia : ia;
    n   = 0;
    while (mag > 0) begin n++; mag = mag / 2; end
    lat = n + 3;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sm, output int lat);
    int g = 0;
    while (!io.in_ready && g < 50) begin @(posedge clk); #1; g++; end
    io.dividend = a; io.divisor = b; io.signed_mode = sm; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    lat = 0;
    while (!io.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!io.out_valid) begin
      checks++; failures++;
      $display("FAIL timeout a=%h b=%h sm=%0d got no out_valid, required within 40 cycles", a, b, sm);
    end
  endtask

  task automatic test_reset;
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.quotient !== 16'd0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", io.quotient); end
    checks++; if (io.remainder !== 16'd0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", io.remainder); end
    checks++; if ({io.div_by_zero, io.overflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {io.div_by_zero, io.overflow}); end
  endtask

  task automatic test_arith;
    logic [15:0] ta[10] = '{16'd100, 16'hFFF9, 16'h0007, 16'h1234, 16'h1234, 16'd0, 16'h8000, 16'hFFFF, 16'h8000, 16'h0001};
    logic [15:0] tb[10] = '{16'd7, 16'h0002, 16'hFFFE, 16'h0000, 16'h0000, 16'd5, 16'hFFFF, 16'h0001, 16'h0003, 16'hFFFF};
    logic        ts[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] a, b, eq, er;
    logic        sm, ed, eo;
    int          el, lat;
    for (int k = 0; k < 70; k++) begin
      if (k < 10) begin a = ta[k]; b = tb[k]; sm = ts[k]; end
      else begin
        a  = 16'($urandom);
        b  = (k % 7 == 0) ? 16'd0 : (k % 3 == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
        if (k % 11 == 0) a = 16'($urandom_range(0, 3));
        sm = 1'($urandom);
      end
      model(a, b, sm, eq, er, ed, eo, el);
      run_op(a, b, sm, lat);
      checks++; if (io.quotient !== eq) begin failures++; $display("FAIL quotient %h/%h sm=%0d got=%h exp=%h", a, b, sm, io.quotient, eq); end
      checks++; if (io.remainder !== er) begin failures++; $display("FAIL remainder %h/%h sm=%0d got=%h exp=%h", a, b, sm, io.remainder, er); end
      checks++; if (io.div_by_zero !== ed) begin failures++; $display("FAIL div_by_zero %h/%h got=%b exp=%b", a, b, io.div_by_zero, ed); end
      checks++; if (io.overflow !== eo) begin failures++; $display("FAIL overflow %h/%h sm=%0d got=%b exp=%b", a, b, sm, io.overflow, eo); end
      checks++; if (lat !== el) begin failures++; $display("FAIL latency %h/%h sm=%0d got=%0d exp=%0d", a, b, sm, lat, el); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] eq, er;
    logic        ed, eo;
    int          el, lat;
    io.out_ready = 1'b0;
    model(16'hFFF9, 16'h0002, 1'b1, eq, er, ed, eo, el);
    run_op(16'hFFF9, 16'h0002, 1'b1, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (io.out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", c, io.out_valid); end
      checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, io.in_ready); end
      checks++; if ({io.quotient, io.remainder} !== {eq, er}) begin failures++; $display("FAIL hold_result cyc=%0d got=%h/%h exp=%h/%h", c, io.quotient, io.remainder, eq, er); end
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin failures++; $display("FAIL release got valid=%b ready=%b exp valid=0 ready=1", io.out_valid, io.in_ready); end
    model(16'd1000, 16'd33, 1'b0, eq, er, ed, eo, el);
    run_op(16'd1000, 16'd33, 1'b0, lat);
    checks++; if ({io.quotient, io.remainder} !== {eq, er}) begin failures++; $display("FAIL b2b_result got=%h/%h exp=%h/%h", io.quotient, io.remainder, eq, er); end
    checks++; if (lat !== el) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, el); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int lat;
    io.dividend = 16'hFFFF; io.divisor = 16'd3; io.signed_mode = 1'b0; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", io.in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL async_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.quotient !== 16'd0) begin failures++; $display("FAIL async_quotient got=%h exp=0", io.quotient); end
    @(negedge clk); rst = 1'b0;
    run_op(16'd50, 16'd5, 1'b0, lat);
    checks++; if ({io.quotient, io.remainder} !== {16'd10, 16'd0}) begin failures++; $display("FAIL after_reset got=%h/%h exp=000a/0000", io.quotient, io.remainder); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL after_reset_latency got=%0d exp=9", lat); end
  endtask

  initial begin
    io.in_valid = 1'b0; io.signed_mode = 1'b0; io.dividend = '0; io.divisor = '0; io.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_arith;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
